// File: rtl/tdc_multichan_readout_if.sv
// ---------------------------------------------------------------------------
// tdc_multichan_readout_if
//   Output hit stream of the multi-channel TDC readout.
//
//   Handshake: a word transfers on a rising edge where out_valid=1 and
//   out_ready=1. While out_valid=1 and out_ready=0 the source holds out_data
//   stable. out_valid does not wait for out_ready, and the sink may change
//   out_ready freely in any cycle.
//
//   Signals:
//     out_valid  source -> sink  word valid
//     out_ready  sink -> source  sink accepts the word
//     out_data   source -> sink  {chan, bc_time, fine}
// ---------------------------------------------------------------------------
interface tdc_multichan_readout_if #(
   parameter int DATA_W = 12
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/tdc_multichan_readout.sv
// ---------------------------------------------------------------------------
// tdc_multichan_readout
//   Stamps decoded fine-time hits from NCHAN channels with the coarse
//   bunch-crossing time. Each hit is buffered in a per-channel FIFO, and the
//   FIFOs are drained round-robin into one registered valid/ready stream.
//   Slow-control readout is provided by per-channel accepted-hit counters,
//   sticky overflow flags and a lockable snapshot of one channel's last hit.
//
//   Ports:
//     clk300        clock, all logic on the rising edge
//     reset         asynchronous active-low reset
//     chan_en       per-channel enable (gates hit_valid only)
//     hit_valid     per-channel one-cycle hit strobe
//     hit_fine      fine codes, channel c at [c*FINE_W +: FINE_W]
//     bc_time       coarse time, sampled together with the hit
//     out_if        output stream (master): out_valid/out_ready/out_data
//     rstr          synchronous clear of tdc_count and tdc_ovf
//     tdc_count     per-channel accepted-hit counters (wrap around)
//     tdc_ovf       sticky per-channel FIFO overflow flags
//     raw_sel       channel shown on tdc_raw
//     tdc_raw_lock  1 = hold tdc_raw
//     tdc_raw       {bc_time, fine} of the last accepted hit on raw_sel
// ---------------------------------------------------------------------------
module tdc_multichan_readout #(
   parameter int  NCHAN    = 4,
   parameter int  FINE_W   = 3,
   parameter int  COARSE_W = 7,
   parameter int  DEPTH    = 4,
   parameter int  CNT_W    = 4,
   localparam int CH_W     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                         clk300,
   input  logic                         reset,
   input  logic [NCHAN-1:0]             chan_en,
   input  logic [NCHAN-1:0]             hit_valid,
   input  logic [NCHAN*FINE_W-1:0]      hit_fine,
   input  logic [COARSE_W-1:0]          bc_time,
   tdc_multichan_readout_if.master      out_if,
   input  logic                         rstr,
   output logic [NCHAN*CNT_W-1:0]       tdc_count,
   output logic [NCHAN-1:0]             tdc_ovf,
   input  logic [CH_W-1:0]              raw_sel,
   input  logic                         tdc_raw_lock,
   output logic [COARSE_W+FINE_W-1:0]   tdc_raw
);
   localparam int ENTRY_W = COARSE_W + FINE_W;
   localparam int AW      = $clog2(DEPTH);
   localparam int OCC_W   = AW + 1;

   logic [ENTRY_W-1:0] mem    [NCHAN][DEPTH];
   logic [AW-1:0]      wr_ptr [NCHAN];
   logic [AW-1:0]      rd_ptr [NCHAN];
   logic [OCC_W-1:0]   occ    [NCHAN];

   logic [NCHAN-1:0]   empty, full, push_req, push_ok, pop, ovf_set;
   logic [CH_W-1:0]    last_gnt, gnt_idx;
   logic               any_req, grant;
   logic [ENTRY_W-1:0] head;

   always_comb begin
      for (int c = 0; c < NCHAN; c++) begin
         empty[c] = (occ[c] == '0);
         full[c]  = (occ[c] == OCC_W'(DEPTH));
      end
   end

   // Round-robin: first non-empty channel above last_gnt, then wrap to the
   // channels at or below it.
   always_comb begin
      gnt_idx = last_gnt;
      any_req = 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
         if (!any_req && !empty[c] && (c > int'(last_gnt))) begin
            any_req = 1'b1;
            gnt_idx = CH_W'(c);
         end
      end
      for (int c = 0; c < NCHAN; c++) begin
         if (!any_req && !empty[c] && (c <= int'(last_gnt))) begin
            any_req = 1'b1;
            gnt_idx = CH_W'(c);
         end
      end
   end

   // The output register can take a new word when empty or being drained.
   assign grant = any_req && (!out_if.out_valid || out_if.out_ready);

   // A push into a full FIFO is still accepted when that FIFO pops on the
   // same edge.
   always_comb begin
      head = '0;
      for (int c = 0; c < NCHAN; c++) begin
         pop[c]      = grant && (gnt_idx == CH_W'(c));
         push_req[c] = hit_valid[c] && chan_en[c];
         push_ok[c]  = push_req[c] && (!full[c] || pop[c]);
         ovf_set[c]  = push_req[c] && !push_ok[c];
         if (gnt_idx == CH_W'(c)) begin
            head = mem[c][rd_ptr[c]];
         end
      end
   end

   always_ff @(posedge clk300) begin
      for (int c = 0; c < NCHAN; c++) begin
         if (push_ok[c]) begin
            mem[c][wr_ptr[c]] <= {bc_time, hit_fine[c*FINE_W +: FINE_W]};
         end
      end
   end

   always_ff @(posedge clk300 or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NCHAN; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            occ[c]    <= '0;
         end
      end else begin
         for (int c = 0; c < NCHAN; c++) begin
            if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
            if (pop[c])     rd_ptr[c] <= rd_ptr[c] + AW'(1);
            if (push_ok[c] && !pop[c]) begin
               occ[c] <= occ[c] + OCC_W'(1);
            end else if (!push_ok[c] && pop[c]) begin
               occ[c] <= occ[c] - OCC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk300 or negedge reset) begin
      if (!reset) begin
         out_if.out_valid <= 1'b0;
         out_if.out_data  <= '0;
         last_gnt         <= CH_W'(NCHAN - 1);
      end else if (grant) begin
         out_if.out_valid <= 1'b1;
         out_if.out_data  <= {gnt_idx, head};
         last_gnt         <= gnt_idx;
      end else if (out_if.out_ready) begin
         out_if.out_valid <= 1'b0;
      end
   end

   // rstr wins over a same-edge increment or overflow.
   always_ff @(posedge clk300 or negedge reset) begin
      if (!reset) begin
         tdc_count <= '0;
         tdc_ovf   <= '0;
      end else if (rstr) begin
         tdc_count <= '0;
         tdc_ovf   <= '0;
      end else begin
         for (int c = 0; c < NCHAN; c++) begin
            if (push_ok[c]) begin
               tdc_count[c*CNT_W +: CNT_W] <= tdc_count[c*CNT_W +: CNT_W] + CNT_W'(1);
            end
            if (ovf_set[c]) tdc_ovf[c] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk300 or negedge reset) begin
      if (!reset) begin
         tdc_raw <= '0;
      end else if (!tdc_raw_lock) begin
         for (int c = 0; c < NCHAN; c++) begin
            if (push_ok[c] && (raw_sel == CH_W'(c))) begin
               tdc_raw <= {bc_time, hit_fine[c*FINE_W +: FINE_W]};
            end
         end
      end
   end
endmodule

// File: tb/tb_tdc_multichan_readout.sv
// ---------------------------------------------------------------------------
// tb_tdc_multichan_readout
//   Directed bench for tdc_multichan_readout with default parameters.
//   Inputs change 1 time unit after the rising edge; registered outputs are
//   read 1 unit after the edge and output words are taken at the falling
//   edge, where out_valid && out_ready means the next edge transfers.
// ---------------------------------------------------------------------------
module tb_tdc_multichan_readout;
   localparam int NCHAN    = 4;
   localparam int FINE_W   = 3;
   localparam int COARSE_W = 7;
   localparam int DEPTH    = 4;
   localparam int CNT_W    = 4;
   localparam int CH_W     = 2;
   localparam int OUT_W    = CH_W + COARSE_W + FINE_W;

   logic                       clk300;
   logic                       reset;
   logic [NCHAN-1:0]           chan_en;
   logic [NCHAN-1:0]           hit_valid;
   logic [NCHAN*FINE_W-1:0]    hit_fine;
   logic [COARSE_W-1:0]        bc_time;
   logic                       rstr;
   logic [NCHAN*CNT_W-1:0]     tdc_count;
   logic [NCHAN-1:0]           tdc_ovf;
   logic [CH_W-1:0]            raw_sel;
   logic                       tdc_raw_lock;
   logic [COARSE_W+FINE_W-1:0] tdc_raw;

   logic [OUT_W-1:0] exp_q[$];
   int n_checks;
   int n_errors;

   tdc_multichan_readout_if #(.DATA_W(OUT_W)) out_if ();

   tdc_multichan_readout #(
      .NCHAN    (NCHAN),
      .FINE_W   (FINE_W),
      .COARSE_W (COARSE_W),
      .DEPTH    (DEPTH),
      .CNT_W    (CNT_W)
   ) dut (
      .clk300       (clk300),
      .reset        (reset),
      .chan_en      (chan_en),
      .hit_valid    (hit_valid),
      .hit_fine     (hit_fine),
      .bc_time      (bc_time),
      .out_if       (out_if),
      .rstr         (rstr),
      .tdc_count    (tdc_count),
      .tdc_ovf      (tdc_ovf),
      .raw_sel      (raw_sel),
      .tdc_raw_lock (tdc_raw_lock),
      .tdc_raw      (tdc_raw)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk300 = 1'b0;
      forever #5 clk300 = ~clk300;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OUT_W-1:0] word(input int ch, input int bc, input int fine);
      return {CH_W'(ch), COARSE_W'(bc), FINE_W'(fine)};
   endfunction

   function automatic int cnt_of(input int ch);
      return int'(tdc_count[ch*CNT_W +: CNT_W]);
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk300) begin
      if (reset && out_if.out_valid && out_if.out_ready) begin
         check_eq("word_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check_eq("out_data", 32'(out_if.out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic cycle();
      @(posedge clk300);
      #1;
      hit_valid = '0;
      rstr      = 1'b0;
   endtask

   task automatic set_hit(input int ch, input int fine);
      hit_valid[ch]                  = 1'b1;
      hit_fine[ch*FINE_W +: FINE_W]  = FINE_W'(fine);
   endtask

   task automatic push_hit(input int ch, input int bc, input int fine);
      bc_time = COARSE_W'(bc);
      set_hit(ch, fine);
      exp_q.push_back(word(ch, bc, fine));
   endtask

   task automatic do_reset();
      reset            = 1'b0;
      chan_en          = '1;
      hit_valid        = '0;
      hit_fine         = '0;
      bc_time          = '0;
      rstr             = 1'b0;
      raw_sel          = '0;
      tdc_raw_lock     = 1'b0;
      out_if.out_ready = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk300);
      #1;
      check_eq("rst_valid", 32'(out_if.out_valid), 32'd0);
      check_eq("rst_data",  32'(out_if.out_data),  32'd0);
      check_eq("rst_count", 32'(tdc_count),        32'd0);
      check_eq("rst_ovf",   32'(tdc_ovf),          32'd0);
      check_eq("rst_raw",   32'(tdc_raw),          32'd0);
      reset = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ord[3];
      n_checks = 0;
      n_errors = 0;

      // 1: single hit, one-cycle latency
      do_reset();
      out_if.out_ready = 1'b1;
      push_hit(1, 'h12, 5);
      cycle();
      check_eq("t1_not_yet", 32'(out_if.out_valid), 32'd0);
      cycle();
      check_eq("t1_valid", 32'(out_if.out_valid), 32'd1);
      check_eq("t1_data",  32'(out_if.out_data),  32'(word(1, 'h12, 5)));
      cycle();
      check_eq("t1_drop",  32'(out_if.out_valid), 32'd0);
      check_eq("t1_count", 32'(cnt_of(1)), 32'd1);

      // 2: overflow under back-pressure, then drain in order
      do_reset();
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            push_hit(2, 'h30 + i, i);
         end else begin
            bc_time = COARSE_W'('h30 + i);
            set_hit(2, i);
         end
         cycle();
      end
      check_eq("t2_ovf",   32'(tdc_ovf),   32'b0100);
      check_eq("t2_count", 32'(cnt_of(2)), 32'd5);
      check_eq("t2_hold",  32'(out_if.out_data), 32'(word(2, 'h30, 0)));
      out_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_eq("t2_stream", 32'(out_if.out_valid), 32'd1);
      end
      cycle();
      check_eq("t2_end",     32'(out_if.out_valid), 32'd0);
      check_eq("t2_drained", 32'(exp_q.size()),     32'd0);
      rstr = 1'b1;
      cycle();
      check_eq("t2_rstr_ovf", 32'(tdc_ovf),   32'd0);
      check_eq("t2_rstr_cnt", 32'(cnt_of(2)), 32'd0);

      // 3: round-robin order
      do_reset();
      out_if.out_ready = 1'b1;
      push_hit(0, 'h40, 1);
      push_hit(1, 'h40, 2);
      push_hit(3, 'h40, 3);
      cycle();
      ord = '{0, 1, 3};
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_eq("t3_valid", 32'(out_if.out_valid), 32'd1);
         check_eq("t3_chan",  32'(out_if.out_data[OUT_W-1 -: CH_W]), 32'(ord[k]));
      end
      push_hit(0, 'h41, 4);
      push_hit(3, 'h41, 5);
      cycle();
      check_eq("t3_gap", 32'(out_if.out_valid), 32'd0);
      cycle();
      check_eq("t3_b_ch0", 32'(out_if.out_data[OUT_W-1 -: CH_W]), 32'd0);
      cycle();
      check_eq("t3_b_ch3", 32'(out_if.out_data[OUT_W-1 -: CH_W]), 32'd3);
      cycle();
      check_eq("t3_end", 32'(out_if.out_valid), 32'd0);

      // 4: toggling back-pressure with continuous ch0 hits
      do_reset();
      for (int i = 0; i < 18; i++) begin
         out_if.out_ready = i[0];
         if (i < 6) push_hit(0, 'h50 + i, i);
         cycle();
      end
      check_eq("t4_end",     32'(out_if.out_valid), 32'd0);
      check_eq("t4_drained", 32'(exp_q.size()),     32'd0);
      check_eq("t4_ovf",     32'(tdc_ovf),          32'd0);
      check_eq("t4_count",   32'(cnt_of(0)),        32'd6);

      // 5: rstr priority and counter wrap
      do_reset();
      out_if.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_hit(0, 'h60 + i, i);
         cycle();
      end
      check_eq("t5_count3", 32'(cnt_of(0)), 32'd3);
      push_hit(0, 'h63, 3);
      rstr = 1'b1;
      cycle();
      check_eq("t5_rstr", 32'(cnt_of(0)), 32'd0);
      for (int i = 0; i < 15; i++) begin
         push_hit(0, i, i);
         cycle();
      end
      check_eq("t5_count15", 32'(cnt_of(0)), 32'd15);
      push_hit(0, 'h7f, 7);
      cycle();
      check_eq("t5_wrap", 32'(cnt_of(0)), 32'd0);
      repeat (3) cycle();
      check_eq("t5_drained", 32'(exp_q.size()), 32'd0);
      check_eq("t5_ovf",     32'(tdc_ovf),      32'd0);

      // 6: raw snapshot, lock, disabled channel, async reset mid-burst
      do_reset();
      out_if.out_ready = 1'b1;
      raw_sel = 2'd3;
      push_hit(3, 'h20, 6);
      cycle();
      check_eq("t6_raw", 32'(tdc_raw), 32'({7'h20, 3'd6}));
      tdc_raw_lock = 1'b1;
      push_hit(3, 'h21, 2);
      cycle();
      check_eq("t6_lock", 32'(tdc_raw), 32'({7'h20, 3'd6}));
      tdc_raw_lock = 1'b0;
      push_hit(1, 'h22, 1);
      cycle();
      check_eq("t6_other_ch", 32'(tdc_raw), 32'({7'h20, 3'd6}));
      raw_sel = 2'd1;
      cycle();
      check_eq("t6_sel_change", 32'(tdc_raw), 32'({7'h20, 3'd6}));
      chan_en = 4'b1011;
      bc_time = 7'h23;
      set_hit(2, 7);
      repeat (3) cycle();
      check_eq("t6_dis_count", 32'(cnt_of(2)),        32'd0);
      check_eq("t6_dis_valid", 32'(out_if.out_valid), 32'd0);
      check_eq("t6_drained",   32'(exp_q.size()),     32'd0);
      chan_en = '1;
      out_if.out_ready = 1'b0;
      raw_sel = 2'd0;
      for (int i = 0; i < 3; i++) begin
         bc_time = COARSE_W'('h70 + i);
         set_hit(0, i + 1);
         set_hit(1, i + 1);
         cycle();
      end
      check_eq("t6_pre_count", 32'(cnt_of(0)), 32'd3);
      #3;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check_eq("t6_ar_valid", 32'(out_if.out_valid), 32'd0);
      check_eq("t6_ar_data",  32'(out_if.out_data),  32'd0);
      check_eq("t6_ar_count", 32'(tdc_count),        32'd0);
      check_eq("t6_ar_ovf",   32'(tdc_ovf),          32'd0);
      check_eq("t6_ar_raw",   32'(tdc_raw),          32'd0);
      cycle();
      reset = 1'b1;
      cycle();
      cycle();
      check_eq("t6_lost", 32'(out_if.out_valid), 32'd0);

      check_eq("final_queue", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/tdc_multichan_readout.md
Name: tdc_multichan_readout

Overview:
Parametrised multi-channel successor to the single-channel TDC channel. It takes N channels of already-decoded fine-time hit codes, stamps each hit with the coarse bunch-crossing time, and buffers it in a per-channel FIFO. A round-robin arbiter drains the FIFOs into one valid/ready hit stream. Per-channel accepted-hit counters, sticky overflow flags and a lockable raw-hit snapshot support slow-control readout. It sits between the per-channel fine-time samplers and the readout serializer, in the clk300 domain.

Parameters:
NCHAN, 4, number of input channels (1..16)
FINE_W, 3, fine-time code width
COARSE_W, 7, bc_time width
DEPTH, 4, per-channel FIFO depth (power of 2, >=2)
CNT_W, 4, width of each per-channel hit counter
CH_W, max(1,clog2(NCHAN)), channel index width (derived, not overridable)

Ports:
clk300  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
chan_en  in  NCHAN  per-channel enable; disabled channel ignores hit_valid
hit_valid  in  NCHAN  one-cycle hit strobe per channel
hit_fine  in  NCHAN*FINE_W  fine code, channel c at [c*FINE_W +: FINE_W]
bc_time  in  COARSE_W  coarse time, sampled with the hit
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_data  out  CH_W+COARSE_W+FINE_W  {chan, bc_time, fine}
rstr  in  1  synchronous clear of counters and overflow flags
tdc_count  out  NCHAN*CNT_W  per-channel accepted-hit counters
tdc_ovf  out  NCHAN  sticky per-channel overflow flags
raw_sel  in  CH_W  channel shown on tdc_raw
tdc_raw_lock  in  1  1 = freeze tdc_raw
tdc_raw  out  COARSE_W+FINE_W  {bc_time, fine} of last accepted hit on raw_sel

Behaviour:
- Reset (reset=0, async): FIFOs empty, out_valid=0, out_data=0, tdc_count=0, tdc_ovf=0, tdc_raw=0, arbiter pointer = channel NCHAN-1, so channel 0 has first priority.
- Capture: at an edge with hit_valid[c]=1 and chan_en[c]=1, the entry {bc_time, hit_fine[c]} is pushed into FIFO c. All channels capture independently on the same edge.
- FIFO full: the push is dropped, tdc_ovf[c] is set (sticky), and tdc_count[c] does not increment. Push and pop on the same edge while full: the pop frees a slot and the push is accepted.
- tdc_count[c]: +1 per accepted push. Wraps modulo 2^CNT_W; it does not saturate.
- rstr=1: clears tdc_count and tdc_ovf on that edge. Clear has priority over a simultaneous increment or overflow. FIFOs, the output stage and tdc_raw are unaffected.
- Arbiter: round-robin over non-empty FIFOs. It searches upward from (last granted + 1) mod NCHAN, wrapping. The pointer updates only on a grant.
- Output register: a grant occurs when a FIFO is non-empty and (out_valid=0 or out_ready=1). On a grant, the winning FIFO pops and out_data/out_valid load on that edge.
- Latency: a hit captured at edge k with an idle output appears with out_valid=1 after edge k+1. Throughput is 1 word/cycle.
- Handshake: when out_valid=1 and out_ready=0, out_data is held stable and no FIFO pops. When out_valid=1 and out_ready=1 with no FIFO pending, out_valid drops after that edge.
- out_data fields: [MSB -: CH_W] = channel index, then the captured bc_time, then the fine code. The stored bc_time is used, not the current one. bc_time wrap-around needs no handling.
- tdc_raw: with tdc_raw_lock=0, it loads {bc_time, fine} on each accepted push to channel raw_sel. With tdc_raw_lock=1, it holds its value. A raw_sel change affects only subsequent pushes.
- Disabled channel: its FIFO still drains normally. Clearing chan_en does not flush the FIFO.
- Reset asserted mid-operation: everything immediately returns to reset values. Buffered hits are lost.

Test Plan:
1. Single hit on ch1, fine=5, bc_time=0x12, out_ready=1 -> one cycle after capture, out_valid=1 for 1 cycle, out_data={1,0x12,5}; tdc_count[1]=1.
2. NCHAN=4, DEPTH=4, out_ready=0, ch2 hits on 6 consecutive edges -> 5 accepted (1 in the output register, 4 in the FIFO), 6th dropped; tdc_ovf[2]=1, tdc_count[2]=5. Then out_ready=1 -> 5 words out in capture order on consecutive cycles.
3. Ch0, ch1 and ch3 hit on the same edge, out_ready=1 -> output order ch0, ch1, ch3 on consecutive cycles. Then ch0 and ch3 hit together -> order ch0, ch3.
4. Back-pressure: out_ready toggles 0/1 every cycle with continuous ch0 hits -> out_data is stable while stalled, no word is lost or duplicated, and no overflow occurs while occupancy is below DEPTH.
5. rstr on the same edge as a ch0 hit with tdc_count[0]=3 -> tdc_count[0]=0, the hit is still output. 16 hits with CNT_W=4 -> the counter wraps to 0.
6. raw_sel=3, tdc_raw_lock=0, ch3 hit {0x20,6} -> tdc_raw={0x20,6}. Set lock=1, then ch3 hit {0x21,2} -> tdc_raw stays {0x20,6}. Assert reset mid-burst -> all outputs 0 asynchronously.
